keypad_scan_controller: RTL and testbench

Sequences the 4x4 keypad. It drives one column low at a time and waits a settle interval before sampling the synchronized rows. A detected press is debounced, then reported as a single-cycle key event with a hex code; the block then tracks hold and release. It sits between the row synchronizer and the keypress store/display path, and replaces the free-running column shifter plus the separate jitter logic.

---
 rtl/keypad_pkg.sv | 52 +++++
 rtl/keypad_scan_controller_if.sv | 29 ++
 rtl/keypad_scan_controller_interval_timer.sv | 32 +++
 rtl/keypad_scan_controller.sv | 145 ++++++++++++++
 tb/tb_keypad_scan_controller.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: scan state enum, KEY_MAP[row][col] hex codes, one-cold column
// drive patterns, and a row decoder that reports the index of a low row plus
// flags for "no row low" and "more than one row low".
package keypad_pkg;

    typedef enum logic [2:0] {
        SETTLE,
        SAMPLE,
        DEBOUNCE_PRESS,
        HELD,
        DEBOUNCE_RELEASE
    } scan_state_e;

    // Rows top to bottom, columns left to right.
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Index j -> vector with only bit j low. Also used as the expected
    // row pattern for a single pressed key in row j.
    localparam logic [3:0] COL_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct packed {
        logic       multi;  // two or more bits low
        logic       none;   // no bit low
        logic [1:0] idx;    // index of a low bit (meaningful when !none && !multi)
    } row_decode_t;

    function automatic row_decode_t onecold_to_idx(input logic [3:0] v);
        row_decode_t d;
        int unsigned zeros;
        d     = '0;
        zeros = 0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) begin
                zeros++;
                d.idx = 2'(i);
            end
        end
        d.none  = (zeros == 0);
        d.multi = (zeros > 1);
        return d;
    endfunction

endpackage

// File: rtl/keypad_scan_controller_if.sv
// Keypad pins and key event bus between the scanner and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: none; key_valid is a single-cycle pulse the consumer must take.
//
// master: the scanner (drives columns and key event outputs, reads rows).
// slave : the surrounding logic (row synchronizer side and key consumer).
interface keypad_scan_controller_if;
    logic [3:0] keypad_hori;  // synchronized rows, active-low
    logic [3:0] keypad_vert;  // column drive, active-low one-cold
    logic       key_valid;    // one-cycle pulse per accepted press
    logic [3:0] key_code;     // hex code of last accepted key
    logic       key_held;     // high from accept until release is debounced

    modport master (
        input  keypad_hori,
        output keypad_vert,
        output key_valid,
        output key_code,
        output key_held
    );

    modport slave (
        output keypad_hori,
        input  keypad_vert,
        input  key_valid,
        input  key_code,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan_controller_interval_timer.sv
// Up-counter with synchronous clear and terminal-count compare for settle/debounce intervals.
// Latency: at_term is combinational from the registered count.
// Backpressure: none; counts only while en is high, clr has priority.
//
// Ports: clk, reset (async active-low), clr, en, term (compare value),
//        at_term (count == term).
module interval_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_term = (cnt == term);

endmodule

// File: rtl/keypad_scan_controller.sv
// Column-scanning 4x4 keypad controller with press/release debounce and hex key events.
// Latency: key_valid rises SETTLE_CYCLES+1+DEBOUNCE_CYCLES cycles after a column's settle entry.
// Backpressure: none; key_valid is a registered one-cycle pulse, key_code holds until the next one.
//
// Ports: clk, reset (async active-low), kp (master modport: keypad_hori in;
//        keypad_vert, key_valid, key_code, key_held out).
module keypad_scan_controller
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 48,
    parameter int DEBOUNCE_CYCLES = 960000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    keypad_scan_controller_if.master kp
);

    localparam logic [CNT_W-1:0] SETTLE_TC   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEBOUNCE_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    scan_state_e state, state_next;
    logic [1:0]  col, col_next;
    logic [1:0]  row, row_next;
    logic [3:0]  vert_q;
    logic        valid_q, valid_next;
    logic [3:0]  code_q, code_next;
    logic        held_q, held_next;

    logic             cnt_en;
    logic             cnt_clr;
    logic             at_term;
    logic [CNT_W-1:0] term;
    row_decode_t      dec;

    assign dec = onecold_to_idx(kp.keypad_hori);

    // Every state change restarts the interval, so no state ever sees a
    // count left over from another.
    assign cnt_clr = (state_next != state);
    assign term    = (state == SETTLE) ? SETTLE_TC : DEBOUNCE_TC;

    interval_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .term    (term),
        .at_term (at_term)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SETTLE;
            col     <= 2'd0;
            row     <= 2'd0;
            vert_q  <= COL_DRIVE[0];
            valid_q <= 1'b0;
            code_q  <= 4'h0;
            held_q  <= 1'b0;
        end else begin
            state   <= state_next;
            col     <= col_next;
            row     <= row_next;
            vert_q  <= COL_DRIVE[col_next];
            valid_q <= valid_next;
            code_q  <= code_next;
            held_q  <= held_next;
        end
    end

    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        valid_next = 1'b0;
        code_next  = code_q;
        held_next  = held_q;
        cnt_en     = 1'b0;

        case (state)
            SETTLE: begin
                cnt_en = 1'b1;
                if (at_term) begin
                    state_next = SAMPLE;
                end
            end

            SAMPLE: begin
                // Ghosting or multi-press looks the same as no key: move on.
                if (dec.none || dec.multi) begin
                    col_next   = col + 2'd1;
                    state_next = SETTLE;
                end else begin
                    row_next   = dec.idx;
                    state_next = DEBOUNCE_PRESS;
                end
            end

            DEBOUNCE_PRESS: begin
                cnt_en = 1'b1;
                // The full row vector must keep exactly the latched row low;
                // any deviation rescans the same column from settle.
                if (kp.keypad_hori != COL_DRIVE[row]) begin
                    state_next = SETTLE;
                end else if (at_term) begin
                    state_next = HELD;
                    valid_next = 1'b1;
                    held_next  = 1'b1;
                    code_next  = KEY_MAP[row][col];
                end
            end

            HELD: begin
                // Only the latched row matters; other keys are ignored.
                if (kp.keypad_hori[row]) begin
                    state_next = DEBOUNCE_RELEASE;
                end
            end

            DEBOUNCE_RELEASE: begin
                cnt_en = 1'b1;
                if (!kp.keypad_hori[row]) begin
                    state_next = HELD;
                end else if (at_term) begin
                    held_next  = 1'b0;
                    col_next   = col + 2'd1;
                    state_next = SETTLE;
                end
            end

            default: begin
                state_next = SETTLE;
            end
        endcase
    end

    assign kp.keypad_vert = vert_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_code    = code_q;
    assign kp.key_held    = held_q;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// Bench for keypad_scan_controller with SETTLE_CYCLES=4, DEBOUNCE_CYCLES=16.
// Table vectors for scan order and multi-press, hand sequences for press,
// bounce, release, reset abort, then random keys against a procedural model.
module tb_keypad_scan_controller;

    localparam int SETTLE = 4;
    localparam int DEB    = 16;
    localparam logic [3:0] KEY_TBL [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    keypad_scan_controller_if kif ();

    keypad_scan_controller #(
        .SETTLE_CYCLES   (SETTLE),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif.master)
    );

    // Physical keypad: a pressed key pulls its row low while its column is
    // driven low. The column is seen one half-cycle late, like a synchronizer.
    logic [15:0] keys        = '0;   // bit r*4+c
    logic        phys_mode   = 1'b0;
    logic [3:0]  direct_hori = 4'hF;
    logic [3:0]  vert_seen   = 4'hF;
    logic [3:0]  phys_hori;

    always @(negedge clk) vert_seen <= kif.keypad_vert;

    always_comb begin
        for (int r = 0; r < 4; r++) phys_hori[r] = ~|(keys[r*4 +: 4] & ~vert_seen);
    end

    assign kif.keypad_hori = phys_mode ? phys_hori : direct_hori;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vert"},  32'(kif.keypad_vert), 32'(4'b1110));
        chk({tag, "_valid"}, 32'(kif.key_valid),   32'(0));
        chk({tag, "_held"},  32'(kif.key_held),    32'(0));
        chk({tag, "_code"},  32'(kif.key_code),    32'(0));
    endtask

    // Ends on a falling edge with reset just released (first settle cycle).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_count(input int n, output int pulses);
        pulses = 0;
        repeat (n) begin
            @(negedge clk);
            if (kif.key_valid) pulses++;
        end
    endtask

    task automatic wait_vert(input logic [3:0] v, input int bound, input string nm);
        int k = 0;
        while (kif.keypad_vert !== v && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(kif.keypad_vert), 32'(v));
    endtask

    task automatic wait_held_low(input int bound, input string nm);
        int k = 0;
        while (kif.key_held !== 1'b0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        chk(nm, 32'(kif.key_held), 32'(0));
    endtask

    // Cycles from now until key_valid is seen (bound+1 if never).
    task automatic wait_pulse(input int bound, output int k);
        k = 0;
        while (k <= bound) begin
            @(negedge clk);
            k++;
            if (kif.key_valid) break;
        end
    endtask

    // ---------------- Reference model ----------------
    // Procedural description of the scan: settle, sample once, need DEB
    // identical samples to accept, then DEB+1 consecutive high samples of the
    // pressed row to release (the first one ends the hold, DEB more confirm).
    logic [3:0] m_vert;
    logic       m_valid;
    logic       m_held;
    logic [3:0] m_code;

    task automatic tick();
        @(posedge clk);
        m_valid = 1'b0;
    endtask

    task automatic model_run();
        int c;
        int r;
        int zeros;
        int run;
        bit ok;
        logic [3:0] h;
        c       = 0;
        m_valid = 1'b0;
        m_held  = 1'b0;
        m_code  = 4'h0;
        forever begin
            m_vert = ~(4'b0001 << c);
            repeat (SETTLE) tick();
            tick();
            h     = kif.keypad_hori;
            zeros = 0;
            r     = 0;
            for (int i = 0; i < 4; i++) begin
                if (!h[i]) begin
                    zeros++;
                    r = i;
                end
            end
            if (zeros != 1) begin
                c = (c + 1) % 4;
                continue;
            end
            ok = 1'b1;
            for (int i = 0; i < DEB; i++) begin
                tick();
                if (kif.keypad_hori != h) begin
                    ok = 1'b0;
                    break;
                end
            end
            if (!ok) continue;
            m_valid = 1'b1;
            m_held  = 1'b1;
            m_code  = KEY_TBL[r*4 + c];
            run     = 0;
            forever begin
                tick();
                if (!kif.keypad_hori[r]) run = 0;
                else begin
                    run++;
                    if (run == DEB + 1) break;
                end
            end
            m_held = 1'b0;
            c      = (c + 1) % 4;
        end
    endtask

    // ---------------- Table vectors ----------------
    typedef struct {
        bit         do_rst;
        logic [3:0] hori;
        int         cycles;
        logic [3:0] vert;
        logic       valid;
        logic       held;
        logic [3:0] code;
    } vec_t;

    localparam int NV = 8;
    vec_t tbl [NV];

    initial begin
        int k;
        int p;
        int p2;
        int hold_left;
        int sel;

        // Idle scan: each column for SETTLE+1 cycles, wrapping to column 0.
        tbl[0] = '{1'b1, 4'hF,    5, 4'b1110, 1'b0, 1'b0, 4'h0};
        tbl[1] = '{1'b0, 4'hF,    5, 4'b1101, 1'b0, 1'b0, 4'h0};
        tbl[2] = '{1'b0, 4'hF,    5, 4'b1011, 1'b0, 1'b0, 4'h0};
        tbl[3] = '{1'b0, 4'hF,    5, 4'b0111, 1'b0, 1'b0, 4'h0};
        tbl[4] = '{1'b0, 4'hF,    5, 4'b1110, 1'b0, 1'b0, 4'h0};
        // Rows 0 and 2 low together: treated as no key, scan keeps moving.
        tbl[5] = '{1'b1, 4'b1010, 5, 4'b1110, 1'b0, 1'b0, 4'h0};
        tbl[6] = '{1'b0, 4'b1010, 5, 4'b1101, 1'b0, 1'b0, 4'h0};
        tbl[7] = '{1'b0, 4'hF,    5, 4'b1011, 1'b0, 1'b0, 4'h0};

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].do_rst) do_reset();
            direct_hori = tbl[i].hori;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                chk($sformatf("tbl%0d_c%0d", i, c),
                    32'({kif.keypad_vert, kif.key_valid, kif.key_held, kif.key_code}),
                    32'({tbl[i].vert, tbl[i].valid, tbl[i].held, tbl[i].code}));
                @(negedge clk);
            end
        end

        // Key "6" (row 1, col 2) held from reset.
        do_reset();
        phys_mode = 1'b1;
        keys      = 16'h1 << 6;
        wait_vert(4'b1011, 40, "t2_col2");
        wait_pulse(40, k);
        chk("t2_latency", 32'(k), 32'(SETTLE + 1 + DEB));
        chk("t2_code", 32'(kif.key_code), 32'(4'h6));
        chk("t2_held", 32'(kif.key_held), 32'(1));
        chk("t2_vert", 32'(kif.keypad_vert), 32'(4'b1011));
        run_count(30, p);
        chk("t2_no_repeat", 32'(p), 32'(0));
        chk("t2_frozen", 32'(kif.keypad_vert), 32'(4'b1011));

        // Key "0" (row 3, col 1) with contact bounce while column 1 is driven.
        keys = '0;
        wait_held_low(60, "t3_prev_release");
        wait_vert(4'b1101, 40, "t3_col1");
        keys = 16'h1 << 13;
        run_count(5, p);
        for (int t = 0; t < 10; t++) begin
            keys = (((t / 3) % 2) == 0) ? 16'h0 : (16'h1 << 13);
            @(negedge clk);
            if (kif.key_valid) p++;
        end
        chk("t3_bounce_pulses", 32'(p), 32'(0));
        keys = 16'h1 << 13;
        run_count(DEB, p);
        chk("t3_early_pulses", 32'(p), 32'(0));
        run_count(100, p);
        chk("t3_one_pulse", 32'(p), 32'(1));
        chk("t3_code", 32'(kif.key_code), 32'(4'h0));

        // Key "A" (row 0, col 3): short release, re-press, long release.
        keys = '0;
        wait_held_low(60, "t4_prev_release");
        keys = 16'h1 << 3;
        wait_pulse(100, k);
        chk("t4_accept", 32'(kif.key_valid), 32'(1));
        chk("t4_code", 32'(kif.key_code), 32'(4'hA));
        keys = '0;
        run_count(8, p);
        chk("t4_held_short_rel", 32'(kif.key_held), 32'(1));
        keys = 16'h1 << 3;
        run_count(5, p2);
        p  = p + p2;
        keys = '0;
        k  = 0;
        while (kif.key_held && k < 40) begin
            @(negedge clk);
            k++;
            if (kif.key_valid) p++;
        end
        // One cycle ends the hold, then DEB confirming release cycles.
        chk("t4_release_cycles", 32'(k), 32'(DEB + 1));
        chk("t4_no_second_pulse", 32'(p), 32'(0));
        chk("t4_resume_col0", 32'(kif.keypad_vert), 32'(4'b1110));
        chk("t4_code_kept", 32'(kif.key_code), 32'(4'hA));

        // Key "2" (row 0, col 1): reset while its press debounce count is 10.
        keys = 16'h1 << 1;
        wait_vert(4'b1101, 40, "t6_col1");
        run_count(SETTLE + 1 + 10, p);
        chk("t6_pre_pulses", 32'(p), 32'(0));
        reset = 1'b0;
        #1;
        chk_reset_vals("t6_abort");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_pulse(60, k);
        // Column 0 pass, then column 1 settle, sample and full debounce.
        chk("t6_fresh_latency", 32'(k), 32'(2 * (SETTLE + 1) + DEB));
        chk("t6_code", 32'(kif.key_code), 32'(4'h2));

        // Random keys against the model.
        keys = '0;
        do_reset();
        fork
            model_run();
        join_none
        hold_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            chk($sformatf("rand_c%0d", cyc),
                32'({kif.keypad_vert, kif.key_valid, kif.key_held, kif.key_code}),
                32'({m_vert, m_valid, m_held, m_code}));
            if (hold_left == 0) begin
                sel = $urandom_range(0, 99);
                if (sel < 35)      keys = '0;
                else if (sel < 85) keys = 16'h1 << $urandom_range(0, 15);
                else               keys = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                hold_left = $urandom_range(3, 70);
            end else begin
                hold_left--;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected finish");
        $fatal(1, "time limit");
    end

endmodule
